conv2d_col2img: RTL and testbench
=================================

CONV2D_COL2IMG -- requirements
Module: conv2d_col2img

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: output pixel width, signed.
REQ-002 SHALL have parameter ACC_WIDTH, default 20: systolic-array accumulator width, signed.
REQ-003 SHALL have parameter OUT_HEIGHT, default 26: output feature-map rows.
REQ-004 SHALL have parameter OUT_WIDTH, default 26: output feature-map columns.
REQ-005 SHALL have parameter KERNEL_NUM, default 1: output channels per beat.
REQ-006 SHALL have parameter SHIFT, default 0: requantization right-shift amount.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-010 SHALL have port in_valid, input, 1 bit: in_data holds one output pixel for all kernels.
REQ-011 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-012 SHALL have port in_data, input, signed, KERNEL_NUM*ACC_WIDTH bits: kernel f at bits [KERNEL_NUM*ACC_WIDTH-1-f*ACC_WIDTH -: ACC_WIDTH].
REQ-013 SHALL have port out_valid, output, 1 bit: out_image holds a complete frame.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer takes the frame.
REQ-015 SHALL have port out_image, output, signed, KERNEL_NUM*OUT_HEIGHT*OUT_WIDTH*BITWIDTH bits: element (k,r,c) at bits [TOTAL-1-((k*OUT_HEIGHT+r)*OUT_WIDTH+c)*BITWIDTH -: BITWIDTH]. This is MSB-first, row-major, and matches the image packing the img2col stage consumes.
REQ-016 SHALL have port pix_cnt, output, clog2(OUT_HEIGHT*OUT_WIDTH+1) bits: beats accepted in the current frame.

Function
REQ-017 SHALL implement two states: COLLECT and HOLD.
REQ-018 SHALL drive in_ready = (state==COLLECT) combinationally, and drive out_valid = (state==HOLD) from a registered state.
REQ-019 SHALL treat a beat as accepted when in_valid && in_ready && !clear at a rising edge.
REQ-020 SHALL process an accepted beat as follows:
- write each kernel f's value to buffer element (f,row,col);
- advance col; on col==OUT_WIDTH-1, wrap col to 0 and increment row;
- increment pix_cnt.
REQ-021 SHALL requantize each value in three steps:
- arithmetic right shift by SHIFT, truncating toward negative infinity, with no rounding;
- saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1];
- store the BITWIDTH-bit result.
REQ-022 SHALL, when the accepted beat is the frame's last (row==OUT_HEIGHT-1, col==OUT_WIDTH-1), enter HOLD in the next cycle, with out_valid=1 one cycle after that beat's edge.
REQ-023 SHALL keep out_valid and out_image stable in HOLD until out_ready is sampled high.
REQ-024 SHALL, on a HOLD edge with out_ready=1, return to COLLECT with row, col and pix_cnt reset to 0.
REQ-025 SHALL allow in_ready=1 in the cycle after the frame handshake; there are no bubble cycles beyond that.
REQ-026 SHALL ignore in_valid in HOLD (backpressure); no data is lost or overwritten.
REQ-027 SHALL, on clear=1 at an edge in any state, force COLLECT, zero row, col and pix_cnt, and discard any coincident beat or out handshake. The buffer is not modified.
REQ-028 SHALL drive out_image continuously from the registered buffer, so a partial frame is visible but qualified only by out_valid.
REQ-029 SHALL keep latency from last accepted beat to out_valid at exactly 1 cycle.
REQ-030 SHALL support a 1x1 frame (OUT_HEIGHT=OUT_WIDTH=1): a single beat completes the frame.

Reset
REQ-031 SHALL, while rst_n=0, immediately force the following regardless of clk:
- state COLLECT;
- row, col, pix_cnt = 0;
- all buffer elements = 0, so out_image = 0;
- out_valid = 0 and in_ready = 1.
REQ-032 SHALL apply reset asserted mid-frame or in HOLD the same way, discarding the partial or held frame.
REQ-033 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-034 Bench SHALL cover the basic frame: OUT_HEIGHT=OUT_WIDTH=2, KERNEL_NUM=1, SHIFT=0; stream 1,2,3,4 with in_valid held -> out_valid rises 1 cycle after 4th beat; out_image = {8'd1,8'd2,8'd3,8'd4} MSB-first; pix_cnt=4.
REQ-035 Bench SHALL cover saturation and shift: SHIFT=2, inputs 600, -600, 7, -1 -> stored 127, -128, 1, -1.
REQ-036 Bench SHALL cover backpressure: complete frame, hold out_ready=0 for 5 cycles while driving in_valid=1 with 9 -> in_ready=0, out_image unchanged; out_ready=1 -> next cycle in_ready=1, pix_cnt=0, and the next beat lands at (0,0).
REQ-037 Bench SHALL cover clear mid-frame: accept 2 beats, assert clear with in_valid=1 -> pix_cnt=0, beat discarded; the next 4 beats form a full frame.
REQ-038 Bench SHALL cover async reset: assert rst_n=0 between clock edges during HOLD -> out_valid=0, out_image=0 immediately, in_ready=1.
REQ-039 Bench SHALL cover two kernels: KERNEL_NUM=2, 2x2 frame, beats {10,-10},{20,-20},{30,-30},{40,-40} -> out_image = 10,20,30,40,-10,-20,-30,-40 MSB-first.

Source files
------------

// File: rtl/conv2d_col2img.sv
// ============================================================================
//  Module   : conv2d_col2img
//  Brief    : Collects a stream of per-pixel systolic-array results (one beat
//             per output pixel, all kernels in parallel), requantizes each
//             value to BITWIDTH, and presents the completed feature map as a
//             packed image held under a valid/ready frame handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2d_col2img #(
  parameter int BITWIDTH   = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_HEIGHT = 26,
  parameter int OUT_WIDTH  = 26,
  parameter int KERNEL_NUM = 1,
  parameter int SHIFT      = 0
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   clear,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic signed [KERNEL_NUM*ACC_WIDTH-1:0]                 in_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic signed [KERNEL_NUM*OUT_HEIGHT*OUT_WIDTH*BITWIDTH-1:0] out_image,
  output logic [$clog2(OUT_HEIGHT*OUT_WIDTH+1)-1:0]              pix_cnt
);

  localparam int c_pix   = OUT_HEIGHT * OUT_WIDTH;
  localparam int c_total = KERNEL_NUM * c_pix * BITWIDTH;
  localparam int c_cnt_w = $clog2(c_pix + 1);
  localparam int c_row_w = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int c_col_w = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  // Working width for saturation: wide enough for both the accumulator and
  // the output range, plus a sign bit so the limits compare cleanly.
  localparam int c_ext_w = ((ACC_WIDTH > BITWIDTH) ? ACC_WIDTH : BITWIDTH) + 1;
  localparam logic signed [c_ext_w-1:0] c_sat_max =
    $signed({{(c_ext_w-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}});
  localparam logic signed [c_ext_w-1:0] c_sat_min = ~c_sat_max;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t               state_q;
  logic [c_row_w-1:0]   row_q;
  logic [c_col_w-1:0]   col_q;
  logic [c_cnt_w-1:0]   pix_cnt_q;
  logic [BITWIDTH-1:0]  img_q [KERNEL_NUM][c_pix];
  logic [BITWIDTH-1:0]  pix_d [KERNEL_NUM];

  logic w_accept;
  logic w_last_pix;

  assign in_ready   = (state_q == S_COLLECT);
  assign out_valid  = (state_q == S_HOLD);
  assign pix_cnt    = pix_cnt_q;
  assign w_accept   = in_valid && in_ready && !clear;
  assign w_last_pix = (row_q == c_row_w'(OUT_HEIGHT - 1)) &&
                      (col_q == c_col_w'(OUT_WIDTH - 1));

  // Per-kernel requantization: floor shift, then clamp to the signed output range.
  for (genvar f = 0; f < KERNEL_NUM; f++) begin : g_quant
    logic signed [ACC_WIDTH-1:0] w_raw;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [c_ext_w-1:0]   w_ext;

    assign w_raw     = in_data[KERNEL_NUM*ACC_WIDTH-1-f*ACC_WIDTH -: ACC_WIDTH];
    assign w_shifted = w_raw >>> SHIFT;
    assign w_ext     = {{(c_ext_w-ACC_WIDTH){w_shifted[ACC_WIDTH-1]}}, w_shifted};
    assign pix_d[f]  = (w_ext > c_sat_max) ? c_sat_max[BITWIDTH-1:0] :
                       (w_ext < c_sat_min) ? c_sat_min[BITWIDTH-1:0] :
                                             w_ext[BITWIDTH-1:0];
  end

  // Pack the buffer MSB-first: kernel-major, then row-major pixels.
  for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_pack_k
    for (genvar p = 0; p < c_pix; p++) begin : g_pack_p
      assign out_image[c_total-1-(k*c_pix+p)*BITWIDTH -: BITWIDTH] = img_q[k][p];
    end
  end

  // Frame buffer: pix_cnt equals row*OUT_WIDTH+col, so it doubles as the write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < KERNEL_NUM; f++) begin
        for (int p = 0; p < c_pix; p++) begin
          img_q[f][p] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int f = 0; f < KERNEL_NUM; f++) begin
        for (int p = 0; p < c_pix; p++) begin
          if (c_cnt_w'(p) == pix_cnt_q) begin
            img_q[f][p] <= pix_d[f];
          end
        end
      end
    end
  end

  // Collect/hold control with raster position tracking; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT;
      row_q     <= '0;
      col_q     <= '0;
      pix_cnt_q <= '0;
    end else if (clear) begin
      state_q   <= S_COLLECT;
      row_q     <= '0;
      col_q     <= '0;
      pix_cnt_q <= '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (w_last_pix) begin
              // Position returns to origin now; pix_cnt keeps the full count while held.
              row_q   <= '0;
              col_q   <= '0;
              state_q <= S_HOLD;
            end else if (col_q == c_col_w'(OUT_WIDTH - 1)) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q   <= S_COLLECT;
            row_q     <= '0;
            col_q     <= '0;
            pix_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= S_COLLECT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_col2img.sv
// ============================================================================
//  Module   : tb_conv2d_col2img
//  Brief    : Bench for conv2d_col2img. Three 2x2 instances run in lockstep
//             (K=1/SHIFT=0, K=1/SHIFT=2, K=2/SHIFT=0) plus a 1x1 instance,
//             all compared against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv2d_col2img;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic out_ready;
  logic [19:0] data1;
  logic [39:0] data2;

  logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [31:0] a_img, b_img;
  logic [63:0] c_img;
  logic [2:0]  a_pix, b_pix, c_pix;

  logic        d_valid, d_ready, d_ir, d_ov;
  logic [19:0] d_data;
  logic [7:0]  d_img;
  logic [0:0]  d_pix;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit         m_hold;
  int         m_pix;
  logic [7:0] m_a [4];
  logic [7:0] m_b [4];
  logic [7:0] m_c [2][4];
  bit         m_d_hold;
  logic [7:0] m_d;

  always #5 clk = ~clk;

  conv2d_col2img #(.BITWIDTH(8), .ACC_WIDTH(20), .OUT_HEIGHT(2), .OUT_WIDTH(2),
                   .KERNEL_NUM(1), .SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(data1), .out_valid(a_ov), .out_ready(out_ready), .out_image(a_img),
    .pix_cnt(a_pix));

  conv2d_col2img #(.BITWIDTH(8), .ACC_WIDTH(20), .OUT_HEIGHT(2), .OUT_WIDTH(2),
                   .KERNEL_NUM(1), .SHIFT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(data1), .out_valid(b_ov), .out_ready(out_ready), .out_image(b_img),
    .pix_cnt(b_pix));

  conv2d_col2img #(.BITWIDTH(8), .ACC_WIDTH(20), .OUT_HEIGHT(2), .OUT_WIDTH(2),
                   .KERNEL_NUM(2), .SHIFT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(c_ir),
    .in_data(data2), .out_valid(c_ov), .out_ready(out_ready), .out_image(c_img),
    .pix_cnt(c_pix));

  conv2d_col2img #(.BITWIDTH(8), .ACC_WIDTH(20), .OUT_HEIGHT(1), .OUT_WIDTH(1),
                   .KERNEL_NUM(1), .SHIFT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(d_valid), .in_ready(d_ir),
    .in_data(d_data), .out_valid(d_ov), .out_ready(d_ready), .out_image(d_img),
    .pix_cnt(d_pix));

  // Floor shift then clamp to signed 8-bit, done with plain integer arithmetic.
  function automatic logic [7:0] rq(input logic [19:0] x, input int sh);
    int v;
    v = int'($signed(x)) >>> sh;
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_pix = 0; m_d_hold = 1'b0; m_d = 8'h00;
    for (int p = 0; p < 4; p++) begin
      m_a[p] = 8'h00; m_b[p] = 8'h00; m_c[0][p] = 8'h00; m_c[1][p] = 8'h00;
    end
  endtask

  // Frame-level behaviour at one rising edge, using the inputs present at it.
  task automatic model_edge();
    if (clear) begin
      m_hold = 1'b0; m_pix = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_a[m_pix]    = rq(data1, 0);
        m_b[m_pix]    = rq(data1, 2);
        m_c[0][m_pix] = rq(data2[39:20], 0);
        m_c[1][m_pix] = rq(data2[19:0], 0);
        m_pix++;
        if (m_pix == 4) m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_hold = 1'b0; m_pix = 0;
    end
    if (clear) begin
      m_d_hold = 1'b0;
    end else if (!m_d_hold) begin
      if (d_valid) begin
        m_d = rq(d_data, 0); m_d_hold = 1'b1;
      end
    end else if (d_ready) begin
      m_d_hold = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ea, eb;
    logic [63:0] ec;
    for (int p = 0; p < 4; p++) begin
      ea[31-p*8 -: 8] = m_a[p];
      eb[31-p*8 -: 8] = m_b[p];
      for (int k = 0; k < 2; k++) ec[63-(k*4+p)*8 -: 8] = m_c[k][p];
    end
    chk({tag, "/a_ov"},  64'(a_ov),  64'(m_hold));
    chk({tag, "/a_ir"},  64'(a_ir),  64'(!m_hold));
    chk({tag, "/a_pix"}, 64'(a_pix), 64'(m_pix));
    chk({tag, "/a_img"}, 64'(a_img), 64'(ea));
    chk({tag, "/b_ov"},  64'(b_ov),  64'(m_hold));
    chk({tag, "/b_pix"}, 64'(b_pix), 64'(m_pix));
    chk({tag, "/b_img"}, 64'(b_img), 64'(eb));
    chk({tag, "/c_ov"},  64'(c_ov),  64'(m_hold));
    chk({tag, "/c_ir"},  64'(c_ir),  64'(!m_hold));
    chk({tag, "/c_pix"}, 64'(c_pix), 64'(m_pix));
    chk({tag, "/c_img"}, c_img, ec);
    chk({tag, "/d_ov"},  64'(d_ov),  64'(m_d_hold));
    chk({tag, "/d_ir"},  64'(d_ir),  64'(!m_d_hold));
    chk({tag, "/d_pix"}, 64'(d_pix), 64'(m_d_hold));
    chk({tag, "/d_img"}, 64'(d_img), 64'(m_d));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic beat(input string tag, input int va, input int vc0, input int vc1);
    in_valid = 1'b1;
    data1    = 20'(va);
    data2    = {20'(vc0), 20'(vc1)};
    tick(tag);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data1 = '0; data2 = '0; d_valid = 1'b0; d_ready = 1'b0; d_data = '0;
    model_reset();
    #12;
    check_all("reset");
    #5 rst_n = 1'b1;
    tick("idle");

    // Basic frame with two kernels alongside
    beat("f1b0", 1, 10, -10);
    beat("f1b1", 2, 20, -20);
    beat("f1b2", 3, 30, -30);
    beat("f1b3", 4, 40, -40);
    chk("basic_ov",  64'(a_ov), 64'd1);
    chk("basic_pix", 64'(a_pix), 64'd4);
    chk("basic_img", 64'(a_img), 64'h01020304);
    chk("shift_small_img", 64'(b_img), 64'h00000001);
    chk("two_kernel_img", c_img, 64'h0A141E28F6ECE2D8);

    // Backpressure: held frame ignores incoming beats
    for (int i = 0; i < 5; i++) begin
      beat("bp_hold", 9, 9, 9);
      chk("bp_in_ready", 64'(a_ir), 64'd0);
      chk("bp_img_stable", 64'(a_img), 64'h01020304);
    end
    out_ready = 1'b1;
    beat("bp_release", 9, 9, 9);
    chk("release_in_ready", 64'(a_ir), 64'd1);
    chk("release_pix", 64'(a_pix), 64'd0);
    out_ready = 1'b0;
    beat("f2b0", 9, 9, 9);
    chk("first_beat_origin", 64'(a_img), 64'h09020304);
    beat("f2b1", 5, 5, 5);

    // Clear mid-frame discards the coincident beat, buffer untouched
    clear = 1'b1;
    beat("clear", 77, 77, 77);
    chk("clear_pix", 64'(a_pix), 64'd0);
    chk("clear_img_kept", 64'(a_img), 64'h09050304);
    clear = 1'b0;

    // Saturation and shift frame
    beat("f3b0", 600, 100000, -3);
    beat("f3b1", -600, -100000, 3);
    beat("f3b2", 7, 127, -128);
    beat("f3b3", -1, 128, -129);
    chk("sat_img_s0", 64'(a_img), 64'h7F8007FF);
    chk("sat_img_s2", 64'(b_img), 64'h7F8001FF);
    chk("sat_ov", 64'(b_ov), 64'd1);

    // Asynchronous reset between edges while holding
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_ov", 64'(a_ov), 64'd0);
    chk("async_rst_img", 64'(a_img), 64'd0);
    chk("async_rst_ir", 64'(a_ir), 64'd1);
    #4 rst_n = 1'b1;
    tick("post_rst");

    // 1x1 frame: a single beat completes it
    d_valid = 1'b1; d_data = 20'(-1000);
    tick("d_single");
    chk("d_single_ov", 64'(d_ov), 64'd1);
    chk("d_single_img", 64'(d_img), 64'h80);
    d_ready = 1'b1; d_data = 20'd50;
    tick("d_release");
    tick("d_again");
    chk("d_again_img", 64'(d_img), 64'h32);

    // Randomized traffic on all instances
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 24) == 0);
      d_valid   = 1'($urandom_range(0, 1));
      d_ready   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        data1 = 20'($urandom);
        data2 = 40'({$urandom, $urandom});
      end else begin
        data1 = 20'(int'($urandom_range(0, 600)) - 300);
        data2 = {20'(int'($urandom_range(0, 300)) - 150), 20'(int'($urandom_range(0, 300)) - 150)};
      end
      d_data = 20'(int'($urandom_range(0, 400)) - 200);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
